raster_block_eval: RTL and testbench
====================================

# raster_block_eval

Rasterizer block evaluator: sits directly downstream of the tile evaluator and consumes the overlapped blocks it emits. For each accepted block (origin x/y, primitive id, three edge equations already evaluated at the block origin), it walks the 2x2 pixel quads of the block in row-major order and tests each pixel against all three edges. For every quad with at least one covered pixel, it emits the quad position, a 4-bit coverage mask and per-pixel edge values toward the fragment/shader interface.

## Interface
Parameters:
- BLOCK_LOGSIZE, 2, log2 of block width/height in pixels; must be >= 1.
- OUT_PIXELS, 4, pixels per quad; fixed, not overridable in practice.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- valid_in  in  1  block request valid.
- xloc_in  in  VX_RASTER_DIM_BITS  block origin x.
- yloc_in  in  VX_RASTER_DIM_BITS  block origin y.
- pid_in  in  VX_RASTER_PID_BITS  primitive id.
- edges_in  in  [2:0][2:0]×RASTER_DATA_BITS  per edge k: [0]=a (x step), [1]=b (y step), [2]=c (value at origin).
- ready_in  out  1  block accepted when valid_in && ready_in.
- valid_out  out  1  quad valid.
- xloc_out  out  VX_RASTER_DIM_BITS  quad origin x.
- yloc_out  out  VX_RASTER_DIM_BITS  quad origin y.
- pid_out  out  VX_RASTER_PID_BITS  primitive id of the quad.
- mask_out  out  4  coverage, bit = 2*py + px.
- bcoords_out  out  [2:0][3:0]×RASTER_DATA_BITS  edge k value at pixel bit index.
- ready_out  in  1  downstream accept.

## Operation
- States: IDLE, SCAN. ready_in = (state == IDLE).
- IDLE: on valid_in && ready_in, latch xloc, yloc, pid, edges; clear quad counter (qx, qy); go to SCAN.
- SCAN: each cycle with advance = ~valid_out || ready_out, evaluate the current quad:
  - For pixel (px, py) with dx = 2*qx + px and dy = 2*qy + py, compute e_k = c_k + a_k*dx + b_k*dy.
  - Compute the multiplies as shift/add of dx and dy (each < 2^BLOCK_LOGSIZE).
  - All arithmetic is modulo 2^RASTER_DATA_BITS (two's complement wrap, no saturation).
  - A pixel is covered iff the sign bit of all three e_k is 0 (zero counts as inside).
- If the quad mask != 0, load the output register with xloc + 2*qx, yloc + 2*qy, pid, mask and the e_k values, and set valid_out. If mask == 0, the quad is dropped; valid_out clears when ready_out consumes the previous quad.
- Counter: qx increments first and wraps at 2^(BLOCK_LOGSIZE-1)-1, then qy increments. After the last quad (qx = qy = max) is evaluated, return to IDLE on the same edge.
- When advance = 0, the counter, state and output register hold. The outputs stay stable while valid_out && ~ready_out.
- pid_out and xloc/yloc come from the output register, not from the latched block; a new block may be latched while the last quad is still pending output.

## Timing
- Reset: state IDLE, valid_out = 0, counter 0. ready_in = 1 in the cycle after reset deasserts. The other outputs are don't-care while valid_out = 0.
- Latency: block accepted at edge E0; quad 0 is evaluated in the following cycle; valid_out is high after E1, provided the quad is non-empty.
- Throughput: 1 quad per cycle under ready_out = 1. Each block occupies SCAN for 4^(BLOCK_LOGSIZE-1) cycles, plus 1 IDLE cycle before the next accept. The default is 4 + 1 = 5 cycles per block.
- Backpressure stalls evaluation even for quads that will be empty.
- Reset mid-SCAN: the current block and the pending quad are discarded with no partial output after reset; the block resumes in IDLE.
- No combinational path from valid_in to valid_out. ready_in does not depend on ready_out combinationally.

## Test plan
- Full cover: a = b = 0, c = 0x100 for all edges, block (8,4), ready_out = 1 -> 4 quads at (8,4), (10,4), (8,6), (10,6), each mask 0xF; ready_in returns at cycle 5.
- Empty block: edge0 c = -1, a = b = 0 -> no valid_out; ready_in is high again 5 cycles after accept.
- Half plane x < 2: edge0 a = -1, b = 0, c = 1, others fully covering -> only quads (qx=0, qy=0) and (qx=0, qy=1), mask 0xF; bcoords edge0 = {0, 1, 0, 1} by bit index 3..0.
- Diagonal: edge0 a = -1, b = -1, c = 1 -> single quad (0,0), mask 0b0111.
- Backpressure: full cover with ready_out low for 3 cycles after the first valid_out -> quad 0 outputs held stable; all 4 quads delivered in order, none lost or duplicated.
- Reset asserted after the 2nd quad is output -> no further valid_out; ready_in = 1 after reset; a new block is processed correctly.

Source files
------------

// File: rtl/raster_block_eval_if.sv
// Block-request and quad-output handshake bundle for the raster block evaluator.
// The slave modport is the evaluator's view; the master modport drives blocks and consumes quads.
interface raster_block_eval_if #(
    parameter int VX_RASTER_DIM_BITS = 16,
    parameter int VX_RASTER_PID_BITS = 8,
    parameter int RASTER_DATA_BITS   = 32
);
    logic                                         valid_in;
    logic [VX_RASTER_DIM_BITS-1:0]                xloc_in;
    logic [VX_RASTER_DIM_BITS-1:0]                yloc_in;
    logic [VX_RASTER_PID_BITS-1:0]                pid_in;
    logic [2:0][2:0][RASTER_DATA_BITS-1:0]        edges_in;
    logic                                         ready_in;

    logic                                         valid_out;
    logic [VX_RASTER_DIM_BITS-1:0]                xloc_out;
    logic [VX_RASTER_DIM_BITS-1:0]                yloc_out;
    logic [VX_RASTER_PID_BITS-1:0]                pid_out;
    logic [3:0]                                   mask_out;
    logic [2:0][3:0][RASTER_DATA_BITS-1:0]        bcoords_out;
    logic                                         ready_out;

    modport slave (
        input  valid_in, xloc_in, yloc_in, pid_in, edges_in,
        output ready_in,
        output valid_out, xloc_out, yloc_out, pid_out, mask_out, bcoords_out,
        input  ready_out
    );

    modport master (
        output valid_in, xloc_in, yloc_in, pid_in, edges_in,
        input  ready_in,
        input  valid_out, xloc_out, yloc_out, pid_out, mask_out, bcoords_out,
        output ready_out
    );
endinterface

// File: rtl/raster_block_eval.sv
// Walks the 2x2 quads of an accepted raster block, tests each pixel against three
// edge equations and emits non-empty quads with coverage mask and per-pixel edge values.
module raster_block_eval #(
    parameter int BLOCK_LOGSIZE      = 2,
    parameter int OUT_PIXELS         = 4,
    parameter int VX_RASTER_DIM_BITS = 16,
    parameter int VX_RASTER_PID_BITS = 8,
    parameter int RASTER_DATA_BITS   = 32
) (
    input  logic               clk,
    input  logic               reset,
    raster_block_eval_if.slave bus
);
    localparam int DW  = RASTER_DATA_BITS;
    localparam int XW  = VX_RASTER_DIM_BITS;
    localparam int QW  = (BLOCK_LOGSIZE > 1) ? BLOCK_LOGSIZE - 1 : 1;
    localparam logic [QW-1:0] QMAX = QW'((1 << (BLOCK_LOGSIZE - 1)) - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t                        state_q, state_d;
    logic [QW-1:0]                 qx_q, qx_d, qy_q, qy_d;
    logic [XW-1:0]                 xloc_q, xloc_d, yloc_q, yloc_d;
    logic [VX_RASTER_PID_BITS-1:0] pid_q, pid_d;
    logic [2:0][2:0][DW-1:0]       edges_q, edges_d;

    logic                          out_valid_q, out_valid_d;
    logic [XW-1:0]                 out_x_q, out_x_d, out_y_q, out_y_d;
    logic [VX_RASTER_PID_BITS-1:0] out_pid_q, out_pid_d;
    logic [3:0]                    out_mask_q, out_mask_d;
    logic [2:0][3:0][DW-1:0]       out_bc_q, out_bc_d;

    logic                          advance_s;
    logic                          last_s;
    logic [3:0]                    mask_s;
    logic [2:0][3:0][DW-1:0]       e_s;

    // c + a*dx + b*dy with the multiplies unrolled into shift/add over the offset bits
    function automatic logic [DW-1:0] edge_eval(
        input logic [DW-1:0]            a,
        input logic [DW-1:0]            b,
        input logic [DW-1:0]            c,
        input logic [BLOCK_LOGSIZE-1:0] dx,
        input logic [BLOCK_LOGSIZE-1:0] dy
    );
        logic [DW-1:0] acc;
        acc = c;
        for (int i = 0; i < BLOCK_LOGSIZE; i++) begin
            if (dx[i]) acc = acc + (a << i);
            else       acc = acc;
            if (dy[i]) acc = acc + (b << i);
            else       acc = acc;
        end
        return acc;
    endfunction

    assign advance_s = ~out_valid_q | bus.ready_out;
    assign last_s    = (qx_q == QMAX) && (qy_q == QMAX);

    // Per-pixel edge values and coverage for the current quad
    always_comb begin
        mask_s = 4'b0000;
        e_s    = '0;
        for (int py = 0; py < 2; py++) begin
            for (int px = 0; px < 2; px++) begin
                for (int k = 0; k < 3; k++) begin
                    e_s[k][2*py+px] = edge_eval(edges_q[k][0], edges_q[k][1], edges_q[k][2],
                                                BLOCK_LOGSIZE'({qx_q, 1'(px)}),
                                                BLOCK_LOGSIZE'({qy_q, 1'(py)}));
                end
                mask_s[2*py+px] = ~(e_s[0][2*py+px][DW-1] | e_s[1][2*py+px][DW-1] |
                                    e_s[2][2*py+px][DW-1]);
            end
        end
    end

    // Next-state, quad counter and output-register load
    always_comb begin
        state_d     = state_q;
        qx_d        = qx_q;
        qy_d        = qy_q;
        xloc_d      = xloc_q;
        yloc_d      = yloc_q;
        pid_d       = pid_q;
        edges_d     = edges_q;
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_pid_d   = out_pid_q;
        out_mask_d  = out_mask_q;
        out_bc_d    = out_bc_q;
        case (state_q)
            IDLE: begin
                if (bus.ready_out) out_valid_d = 1'b0;
                else               out_valid_d = out_valid_q;
                if (bus.valid_in) begin
                    xloc_d  = bus.xloc_in;
                    yloc_d  = bus.yloc_in;
                    pid_d   = bus.pid_in;
                    edges_d = bus.edges_in;
                    qx_d    = '0;
                    qy_d    = '0;
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (advance_s) begin
                    if (mask_s != 4'b0000) begin
                        out_valid_d = 1'b1;
                        out_x_d     = xloc_q + XW'({qx_q, 1'b0});
                        out_y_d     = yloc_q + XW'({qy_q, 1'b0});
                        out_pid_d   = pid_q;
                        out_mask_d  = mask_s;
                        out_bc_d    = e_s;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                    if (last_s) begin
                        qx_d    = '0;
                        qy_d    = '0;
                        state_d = IDLE;
                    end else if (qx_q == QMAX) begin
                        qx_d = '0;
                        qy_d = qy_q + QW'(1);
                    end else begin
                        qx_d = qx_q + QW'(1);
                    end
                end else begin
                    state_d = SCAN;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State, latched block and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            qx_q        <= '0;
            qy_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            qx_q        <= qx_d;
            qy_q        <= qy_d;
            out_valid_q <= out_valid_d;
        end
        xloc_q     <= xloc_d;
        yloc_q     <= yloc_d;
        pid_q      <= pid_d;
        edges_q    <= edges_d;
        out_x_q    <= out_x_d;
        out_y_q    <= out_y_d;
        out_pid_q  <= out_pid_d;
        out_mask_q <= out_mask_d;
        out_bc_q   <= out_bc_d;
    end

    assign bus.ready_in    = (state_q == IDLE);
    assign bus.valid_out   = out_valid_q;
    assign bus.xloc_out    = out_x_q;
    assign bus.yloc_out    = out_y_q;
    assign bus.pid_out     = out_pid_q;
    assign bus.mask_out    = out_mask_q;
    assign bus.bcoords_out = out_bc_q;
endmodule

// File: tb/tb_raster_block_eval.sv
// Directed bench for raster_block_eval: full/empty/half-plane/diagonal blocks,
// output backpressure and reset in the middle of a scan.
module tb_raster_block_eval;
    logic clk;
    logic reset;

    raster_block_eval_if #(.VX_RASTER_DIM_BITS(16), .VX_RASTER_PID_BITS(8),
                           .RASTER_DATA_BITS(32)) ifc ();

    raster_block_eval #(.BLOCK_LOGSIZE(2), .OUT_PIXELS(4), .VX_RASTER_DIM_BITS(16),
                        .VX_RASTER_PID_BITS(8), .RASTER_DATA_BITS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [15:0]  q_x[$];
    logic [15:0]  q_y[$];
    logic [7:0]   q_pid[$];
    logic [3:0]   q_mask[$];
    logic [127:0] q_bc0[$];

    logic [2:0][2:0][31:0] edg;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record every quad that is handed over (valid && ready) at the next rising edge
    always @(negedge clk) begin
        if (!reset && ifc.valid_out && ifc.ready_out) begin
            q_x.push_back(ifc.xloc_out);
            q_y.push_back(ifc.yloc_out);
            q_pid.push_back(ifc.pid_out);
            q_mask.push_back(ifc.mask_out);
            q_bc0.push_back(ifc.bcoords_out[0]);
        end
    end

    task automatic clear_q();
        q_x.delete(); q_y.delete(); q_pid.delete(); q_mask.delete(); q_bc0.delete();
    endtask

    // Edge 0 is the edge under test; edges 1 and 2 always cover the whole block
    task automatic set_edges(input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] c0);
        edg = '0;
        edg[0][0] = a0;
        edg[0][1] = b0;
        edg[0][2] = c0;
        edg[1][2] = 32'h0000_0100;
        edg[2][2] = 32'h0000_0100;
    endtask

    // Returns with the block accepted and valid_out sampled just after the following edge
    task automatic accept_block(input logic [15:0] x, input logic [15:0] y,
                                input logic [7:0] pid, output logic fv);
        int n;
        n = 0;
        @(negedge clk);
        while (!ifc.ready_in && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.ready_in) chk("accept_timeout", 128'd0, 128'd1);
        ifc.valid_in = 1'b1;
        ifc.xloc_in  = x;
        ifc.yloc_in  = y;
        ifc.pid_in   = pid;
        ifc.edges_in = edg;
        @(posedge clk);
        #1 ifc.valid_in = 1'b0;
        @(posedge clk);
        #1 fv = ifc.valid_out;
    endtask

    // Counts accept-to-ready edges (one already elapsed inside accept_block)
    task automatic wait_idle(output int n);
        n = 1;
        while (!ifc.ready_in && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        if (!ifc.ready_in) chk("idle_timeout", 128'd0, 128'd1);
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_full_cover(input string tag, input logic [7:0] pid);
        chk({tag, "_count"}, 128'(q_x.size()), 128'd4);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_x"},    128'(q_x[i]),    128'(16'd8 + 16'(2 * (i % 2))));
            chk({tag, "_y"},    128'(q_y[i]),    128'(16'd4 + 16'(2 * (i / 2))));
            chk({tag, "_mask"}, 128'(q_mask[i]), 128'(4'hF));
            chk({tag, "_pid"},  128'(q_pid[i]),  128'(pid));
        end
        chk({tag, "_bc0"}, q_bc0[3], {4{32'h0000_0100}});
    endtask

    initial begin
        logic fv;
        int   n;

        reset         = 1'b1;
        ifc.valid_in  = 1'b0;
        ifc.xloc_in   = 16'd0;
        ifc.yloc_in   = 16'd0;
        ifc.pid_in    = 8'd0;
        ifc.edges_in  = '0;
        ifc.ready_out = 1'b1;
        edg           = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_ready_in", 128'(ifc.ready_in), 128'd1);
        chk("rst_valid_out", 128'(ifc.valid_out), 128'd0);

        // Full cover: four quads, next accept five cycles after this one
        clear_q();
        set_edges(32'd0, 32'd0, 32'h0000_0100);
        accept_block(16'd8, 16'd4, 8'd5, fv);
        chk("full_latency", 128'(fv), 128'd1);
        wait_idle(n);
        chk("full_spacing", 128'(n + 1), 128'd5);
        drain();
        check_full_cover("full", 8'd5);

        // Empty block: nothing emitted, same block occupancy
        clear_q();
        set_edges(32'd0, 32'd0, 32'hFFFF_FFFF);
        accept_block(16'd40, 16'd40, 8'd1, fv);
        chk("empty_valid", 128'(fv), 128'd0);
        wait_idle(n);
        chk("empty_spacing", 128'(n + 1), 128'd5);
        drain();
        chk("empty_count", 128'(q_x.size()), 128'd0);

        // Half plane x < 2: e0 = 1 - dx
        clear_q();
        set_edges(32'hFFFF_FFFF, 32'd0, 32'd1);
        accept_block(16'd0, 16'd0, 8'd7, fv);
        wait_idle(n);
        drain();
        chk("half_count", 128'(q_x.size()), 128'd2);
        chk("half_x0", 128'(q_x[0]), 128'd0);
        chk("half_y0", 128'(q_y[0]), 128'd0);
        chk("half_m0", 128'(q_mask[0]), 128'(4'hF));
        chk("half_bc0", q_bc0[0], {32'd0, 32'd1, 32'd0, 32'd1});
        chk("half_x1", 128'(q_x[1]), 128'd0);
        chk("half_y1", 128'(q_y[1]), 128'd2);
        chk("half_m1", 128'(q_mask[1]), 128'(4'hF));
        chk("half_bc1", q_bc0[1], {32'd0, 32'd1, 32'd0, 32'd1});
        chk("half_pid", 128'(q_pid[1]), 128'd7);

        // Diagonal: e0 = 1 - dx - dy, only pixel (1,1) of quad 0 fails
        clear_q();
        set_edges(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
        accept_block(16'd20, 16'd30, 8'd9, fv);
        wait_idle(n);
        drain();
        chk("diag_count", 128'(q_x.size()), 128'd1);
        chk("diag_x", 128'(q_x[0]), 128'd20);
        chk("diag_y", 128'(q_y[0]), 128'd30);
        chk("diag_mask", 128'(q_mask[0]), 128'(4'b0111));
        chk("diag_bc0", q_bc0[0], {32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1});

        // Backpressure: quad 0 held for three cycles, then all four in order
        clear_q();
        set_edges(32'd0, 32'd0, 32'h0000_0100);
        ifc.ready_out = 1'b0;
        accept_block(16'd8, 16'd4, 8'd3, fv);
        chk("bp_latency", 128'(fv), 128'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 128'(ifc.valid_out), 128'd1);
            chk("bp_hold_x", 128'(ifc.xloc_out), 128'd8);
            chk("bp_hold_y", 128'(ifc.yloc_out), 128'd4);
            chk("bp_hold_ready_in", 128'(ifc.ready_in), 128'd0);
        end
        ifc.ready_out = 1'b1;
        wait_idle(n);
        drain();
        check_full_cover("bp", 8'd3);

        // Reset after the second quad has been handed over
        clear_q();
        set_edges(32'd0, 32'd0, 32'h0000_0100);
        accept_block(16'd8, 16'd4, 8'd2, fv);
        n = 0;
        while (q_x.size() < 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (q_x.size() < 2) chk("rst_mid_timeout", 128'd0, 128'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_mid_ready_in", 128'(ifc.ready_in), 128'd1);
        chk("rst_mid_valid_out", 128'(ifc.valid_out), 128'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("rst_mid_count", 128'(q_x.size()), 128'd2);
        clear_q();
        set_edges(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
        accept_block(16'd20, 16'd30, 8'd9, fv);
        wait_idle(n);
        drain();
        chk("post_rst_count", 128'(q_x.size()), 128'd1);
        chk("post_rst_x", 128'(q_x[0]), 128'd20);
        chk("post_rst_mask", 128'(q_mask[0]), 128'(4'b0111));
        chk("post_rst_pid", 128'(q_pid[0]), 128'd9);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
